// File: rtl/fp_wb_arbiter_if.sv
// Bundle of the FP write-back arbiter's handshake and bus signals.
//   src_valid/src_rd/src_data/src_fflags : finished results from the FP units
//   src_ready                            : per-source accept, same cycle as grant
//   stall_wb                             : write-back hold request from the pipeline
//   wb_valid/waddr_wb/wdata_wb/fflags_wb : registered write-back payload
//   fp_reg_write_wb                      : commit strobe (RF write enable / busy clear)
//   all_uu_FP_rd                         : per-source in-flight rd for the busy tracker
// Modport master is the arbiter side; modport slave is the surrounding pipeline.
interface fp_wb_arbiter_if #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FLAG_W     = 5,
    parameter int unsigned TOTAL_REGS = 32
);
    localparam int unsigned AW = $clog2(TOTAL_REGS);

    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0][AW-1:0]   src_rd;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0][FLAG_W-1:0] src_fflags;
    logic [NUM_SRC-1:0]           src_ready;
    logic                         stall_wb;
    logic                         wb_valid;
    logic [AW-1:0]                waddr_wb;
    logic [DATA_W-1:0]            wdata_wb;
    logic [FLAG_W-1:0]            fflags_wb;
    logic                         fp_reg_write_wb;
    logic [NUM_SRC-1:0][AW-1:0]   all_uu_FP_rd;

    modport master (
        input  src_valid, src_rd, src_data, src_fflags, stall_wb,
        output src_ready, wb_valid, waddr_wb, wdata_wb, fflags_wb,
               fp_reg_write_wb, all_uu_FP_rd
    );

    modport slave (
        output src_valid, src_rd, src_data, src_fflags, stall_wb,
        input  src_ready, wb_valid, waddr_wb, wdata_wb, fflags_wb,
               fp_reg_write_wb, all_uu_FP_rd
    );
endinterface

// File: rtl/fp_wb_arbiter.sv
// Round-robin write-back arbiter for the FP register file.
// Picks one finished result per cycle from the FP add, mul and div/sqrt units,
// registers it, and presents it as the register-file write / busy-clear port.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : fp_wb_arbiter_if.master (source handshakes, stall, write-back outputs,
//           in-flight rd pass-through)
module fp_wb_arbiter #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FLAG_W     = 5,
    parameter int unsigned TOTAL_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    fp_wb_arbiter_if.master bus
);
    localparam int unsigned AW    = $clog2(TOTAL_REGS);
    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Output register and round-robin pointer
    logic                wb_valid;
    logic [AW-1:0]       waddr;
    logic [DATA_W-1:0]   wdata;
    logic [FLAG_W-1:0]   fflags;
    logic [IDX_W-1:0]    rr_ptr;

    // Arbitration results
    logic                can_load;
    logic [NUM_SRC-1:0]  grant;
    logic                grant_any;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    scan_idx;
    logic [IDX_W-1:0]    next_ptr;

    // Output register is empty or its content commits this cycle
    assign can_load = ~wb_valid | ~bus.stall_wb;

    // Scan from rr_ptr upward (mod NUM_SRC); first valid source wins
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr) + k) % NUM_SRC);
            if (!grant_any && bus.src_valid[scan_idx]) begin
                grant_any       = 1'b1;
                grant_idx       = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // Pointer moves one past the granted source
    always_comb begin
        next_ptr = IDX_W'(grant_idx + 1'b1);
        if (32'(grant_idx) == NUM_SRC - 1) begin
            next_ptr = '0;
        end
    end

    // Accept is withheld while in reset so no source pops a result that is then cleared
    assign bus.src_ready = grant & {NUM_SRC{can_load & ~reset}};

    // Write-back register; data fields only change on a handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            fflags   <= '0;
            rr_ptr   <= '0;
        end else if (can_load) begin
            if (grant_any) begin
                wb_valid <= 1'b1;
                waddr    <= bus.src_rd[grant_idx];
                wdata    <= bus.src_data[grant_idx];
                fflags   <= bus.src_fflags[grant_idx];
                rr_ptr   <= next_ptr;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign bus.wb_valid        = wb_valid;
    assign bus.waddr_wb        = waddr;
    assign bus.wdata_wb        = wdata;
    assign bus.fflags_wb       = fflags;

    // Commit strobe: one pulse per held result, on the cycle it leaves the register
    assign bus.fp_reg_write_wb = wb_valid & ~bus.stall_wb;

    // In-flight rd reported to the busy tracker regardless of valid
    assign bus.all_uu_FP_rd    = bus.src_rd;

    // At most one grant per cycle
    grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

    // A pending source keeps its result presented until accepted
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_hold
        src_hold: assert property (@(posedge clk) disable iff (reset)
            (bus.src_valid[gi] && !bus.src_ready[gi]) |=> bus.src_valid[gi]);
    end
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench for fp_wb_arbiter: stimulus queues results per source and
// pushes the hand-derived commit order; a monitor pops on every commit strobe.
module tb_fp_wb_arbiter;
    localparam int unsigned NUM_SRC    = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FLAG_W     = 5;
    localparam int unsigned TOTAL_REGS = 32;
    localparam int unsigned AW         = 5;

    typedef struct packed {
        logic [AW-1:0]     rd;
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] ff;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_wb_arbiter_if #(
        .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .FLAG_W(FLAG_W), .TOTAL_REGS(TOTAL_REGS)
    ) bus ();

    fp_wb_arbiter #(
        .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .FLAG_W(FLAG_W), .TOTAL_REGS(TOTAL_REGS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    item_t srcq [NUM_SRC][$];
    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue a result at a source; committed results also go to the scoreboard
    task automatic put(input int s, input logic [AW-1:0] rd, input logic [DATA_W-1:0] data,
                       input logic [FLAG_W-1:0] ff, input bit committed);
        item_t it;
        it.rd   = rd;
        it.data = data;
        it.ff   = ff;
        srcq[s].push_back(it);
        if (committed) exp_q.push_back(it);
    endtask

    // Present each source's oldest pending result; idle sources show a marker rd
    task automatic drive_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (srcq[i].size() > 0) begin
                bus.src_valid[i]  = 1'b1;
                bus.src_rd[i]     = srcq[i][0].rd;
                bus.src_data[i]   = srcq[i][0].data;
                bus.src_fflags[i] = srcq[i][0].ff;
            end else begin
                bus.src_valid[i]  = 1'b0;
                bus.src_rd[i]     = AW'(29 + i);
                bus.src_data[i]   = '0;
                bus.src_fflags[i] = '0;
            end
        end
    endtask

    // One clock: drive, check accept pattern mid-cycle, pop accepted sources
    task automatic cyc(input logic stall, input logic [NUM_SRC-1:0] exp_ready, input string tag);
        logic [NUM_SRC-1:0] hs;
        bus.stall_wb = stall;
        drive_srcs();
        @(negedge clk);
        check({tag, "_src_ready"}, 32'(bus.src_ready), 32'(exp_ready));
        hs = bus.src_valid & bus.src_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) void'(srcq[i].pop_front());
        end
    endtask

    // Monitor: every commit strobe must match the next expected result
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (bus.fp_reg_write_wb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got rd 0x%0h expected no commit", bus.waddr_wb);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_waddr",  32'(bus.waddr_wb),  32'(e.rd));
                    check("commit_wdata",  bus.wdata_wb,       e.data);
                    check("commit_fflags", 32'(bus.fflags_wb), 32'(e.ff));
                    check("commit_valid",  32'(bus.wb_valid),  32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.stall_wb = 1'b0;
        drive_srcs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid",  32'(bus.wb_valid),        32'd0);
        check("rst_strobe",    32'(bus.fp_reg_write_wb), 32'd0);
        check("rst_waddr",     32'(bus.waddr_wb),        32'd0);
        check("rst_wdata",     bus.wdata_wb,             32'd0);
        check("rst_fflags",    32'(bus.fflags_wb),       32'd0);
        check("rst_src_ready", 32'(bus.src_ready),       32'd0);
        check("rd_passthru",   32'(bus.all_uu_FP_rd),    32'({5'd31, 5'd30, 5'd29}));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single source 1, rd 7
        put(1, 5'd7, 32'h3F80_0000, 5'b00000, 1'b1);
        cyc(1'b0, 3'b010, "single");
        check("single_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("single_waddr",    32'(bus.waddr_wb), 32'd7);
        cyc(1'b0, 3'b000, "single_drain");
        cyc(1'b0, 3'b000, "single_idle");

        // rr_ptr is 2; one grant to source 2 brings it back to 0
        put(2, 5'd3, 32'h4000_0000, 5'b00000, 1'b1);
        cyc(1'b0, 3'b100, "align");

        // All three continuously valid: 0,1,2,0,1,2
        for (int j = 0; j < 2; j++) begin
            put(0, AW'(10 + j), 32'hA000_0000 + 32'(j), 5'b00000, 1'b1);
            put(1, AW'(13 + j), 32'hB000_0000 + 32'(j), 5'b00000, 1'b1);
            put(2, AW'(16 + j), 32'hC000_0000 + 32'(j), 5'b00000, 1'b1);
        end
        cyc(1'b0, 3'b001, "rr0");
        cyc(1'b0, 3'b010, "rr1");
        cyc(1'b0, 3'b100, "rr2");
        cyc(1'b0, 3'b001, "rr3");
        cyc(1'b0, 3'b010, "rr4");
        cyc(1'b0, 3'b100, "rr5");
        cyc(1'b0, 3'b000, "rr_drain");
        cyc(1'b0, 3'b000, "rr_idle");

        // Stall: rd 12 from source 2 held for 3 cycles while 0 and 2 wait
        put(2, 5'd12, 32'hC120_0000, 5'b00000, 1'b1);
        cyc(1'b0, 3'b100, "stall_load");
        put(0, 5'd20, 32'h0000_0020, 5'b00000, 1'b1);
        put(2, 5'd21, 32'h0000_0021, 5'b00000, 1'b1);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 3'b000, "stall");
            check("stall_wb_valid", 32'(bus.wb_valid),        32'd1);
            check("stall_waddr",    32'(bus.waddr_wb),        32'd12);
            check("stall_wdata",    bus.wdata_wb,             32'hC120_0000);
            check("stall_strobe",   32'(bus.fp_reg_write_wb), 32'd0);
        end
        cyc(1'b0, 3'b001, "release");
        cyc(1'b0, 3'b100, "after_release");
        cyc(1'b0, 3'b000, "stall_drain");
        cyc(1'b0, 3'b000, "stall_idle");

        // Priority: rr_ptr 1, source 2 beats source 0's second grant
        put(0, 5'd1, 32'h0000_0001, 5'b00000, 1'b1);
        cyc(1'b0, 3'b001, "setptr");
        put(2, 5'd4, 32'h0000_0004, 5'b00000, 1'b1);
        put(0, 5'd2, 32'h0000_0002, 5'b00000, 1'b1);
        put(0, 5'd8, 32'h0000_0008, 5'b00000, 1'b1);
        cyc(1'b0, 3'b100, "prio_div");
        cyc(1'b0, 3'b001, "prio_add");
        cyc(1'b0, 3'b001, "prio_add2");
        cyc(1'b0, 3'b000, "prio_drain");
        cyc(1'b0, 3'b000, "prio_idle");

        // Flag path: NX from source 1
        put(1, 5'd9, 32'h3DCC_CCCD, 5'b00001, 1'b1);
        cyc(1'b0, 3'b010, "flag");
        cyc(1'b0, 3'b000, "flag_drain");
        cyc(1'b0, 3'b000, "flag_idle");

        // Reset while rd 5 is held: result is lost, pointer returns to 0
        put(1, 5'd5, 32'h1111_1111, 5'b00000, 1'b0);
        cyc(1'b0, 3'b010, "rst_load");
        check("pre_rst_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("pre_rst_waddr",    32'(bus.waddr_wb), 32'd5);
        reset = 1'b1;
        put(1, 5'd6, 32'h0000_0006, 5'b00000, 1'b1);
        put(2, 5'd7, 32'h0000_0007, 5'b00000, 1'b1);
        drive_srcs();
        #1;
        check("midrst_wb_valid", 32'(bus.wb_valid),        32'd0);
        check("midrst_strobe",   32'(bus.fp_reg_write_wb), 32'd0);
        check("midrst_waddr",    32'(bus.waddr_wb),        32'd0);
        @(negedge clk);
        check("midrst_src_ready", 32'(bus.src_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 3'b010, "post_rst");
        cyc(1'b0, 3'b100, "post_rst2");
        cyc(1'b0, 3'b000, "post_rst_drain");
        cyc(1'b0, 3'b000, "post_rst_idle");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
